fir_coef_ctrl: RTL and testbench

Configuration controller for the 2D FIR filter's 3x3 kernel. Selects a kernel preset from switches or a debounced button and streams 9 signed coefficients plus a normalisation shift into the filter's shadow bank over a valid/ready write port. Commits the bank with a one-cycle swap pulse on the next vertical-sync rising edge, so kernels never change mid-frame. Sits beside fir_filter in hdmi_top, clocked in the filter's clock domain.

---
 rtl/fir_coef_ctrl.sv | 263 ++++++++++++++++++++++++++
 tb/tb_fir_coef_ctrl.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_coef_ctrl.sv
// Kernel preset controller for the 3x3 FIR: streams 9 taps + shift into the shadow bank and swaps on vsync.
// Optional macro FIR_COEF_VS_TIMEOUT_EN: forces the swap after VS_TIMEOUT_CYC cycles in WAIT_VS and sets timeout_o.
module fir_coef_ctrl #(
    parameter int COEF_W         = 8,
    parameter int SHIFT_W        = 4,
    parameter int DEBOUNCE_CYC   = 1000000,
    parameter int VS_TIMEOUT_CYC = 4000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        sw_i,
    input  logic [3:0]        bt_i,
    input  logic              vs_i,
    output logic              coef_valid_o,
    input  logic              coef_ready_i,
    output logic [3:0]        coef_addr_o,
    output logic [COEF_W-1:0] coef_data_o,
    output logic              coef_swap_o,
    output logic              bypass_o,
    output logic [1:0]        preset_o,
    output logic              busy_o,
    output logic              timeout_o
);

    localparam int DB_W = $clog2(DEBOUNCE_CYC + 1);

    if (DEBOUNCE_CYC < 1 || VS_TIMEOUT_CYC < 1) begin : g_bad_cfg
        $error("fir_coef_ctrl: DEBOUNCE_CYC and VS_TIMEOUT_CYC must be >= 1");
    end

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOAD    = 2'd1,
        ST_WAIT_VS = 2'd2,
        ST_SWAP    = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              bt_meta_q, bt_meta_d;
    logic              bt_sync_q, bt_sync_d;
    logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
    logic              db_level_q, db_level_d;
    logic [2:0]        sw_s_q, sw_s_d;
    logic [2:0]        sw_prev_q, sw_prev_d;
    logic              vs_s_q, vs_s_d;
    logic              vs_prev_q, vs_prev_d;
    logic              pending_q, pending_d;
    logic [1:0]        target_q, target_d;
    logic [1:0]        work_preset_q, work_preset_d;
    logic              work_bypass_q, work_bypass_d;
    logic [3:0]        addr_q, addr_d;
    logic [1:0]        preset_q, preset_d;
    logic              bypass_q, bypass_d;

    logic              bt_press;
    logic              sel_chg;
    logic              byp_chg;
    logic              vs_rise;
    logic              load_take;
    logic              to_expire;
    logic              unused_in;

    assign unused_in = ^{sw_i[6:2], bt_i[3:1]};
    assign load_take = (state_q == ST_IDLE) && pending_q;
    assign vs_rise   = vs_s_q && !vs_prev_q;

    // Tap order is row-major; address 9 carries the zero-extended shift.
    function automatic logic [COEF_W-1:0] rom_word(input logic [1:0] p, input logic [3:0] a);
        int                 c;
        logic [SHIFT_W-1:0] sh;
        c  = 0;
        sh = (p == 2'd1) ? SHIFT_W'(4) : '0;
        case (a)
            4'd4: begin
                case (p)
                    2'd0:    c = 1;
                    2'd1:    c = 4;
                    2'd2:    c = 5;
                    default: c = 8;
                endcase
            end
            4'd1, 4'd3, 4'd5, 4'd7: begin
                case (p)
                    2'd0:    c = 0;
                    2'd1:    c = 2;
                    default: c = -1;
                endcase
            end
            4'd0, 4'd2, 4'd6, 4'd8: begin
                case (p)
                    2'd1:    c = 1;
                    2'd3:    c = -1;
                    default: c = 0;
                endcase
            end
            default: c = 0;
        endcase
        if (a == 4'd9) begin
            return COEF_W'(sh);
        end
        return COEF_W'(c);
    endfunction

    // Input conditioning: button sync + debounce, switch and vsync edge detection, request tracking.
    always_comb begin
        bt_meta_d  = bt_i[0];
        bt_sync_d  = bt_meta_q;
        db_cnt_d   = db_cnt_q;
        db_level_d = db_level_q;
        bt_press   = 1'b0;
        if (bt_sync_q == db_level_q) begin
            db_cnt_d = '0;
        end else if (db_cnt_q == DB_W'(DEBOUNCE_CYC - 1)) begin
            db_cnt_d   = '0;
            db_level_d = bt_sync_q;
            bt_press   = bt_sync_q;
        end else begin
            db_cnt_d = db_cnt_q + 1'b1;
        end

        sw_s_d    = {sw_i[7], sw_i[1:0]};
        sw_prev_d = sw_s_q;
        sel_chg   = (sw_s_q[1:0] != sw_prev_q[1:0]);
        byp_chg   = (sw_s_q[2] != sw_prev_q[2]);

        vs_s_d    = vs_i;
        vs_prev_d = vs_s_q;

        target_d = target_q;
        if (bt_press) begin
            target_d = target_q + 2'd1;
        end
        if (sel_chg) begin
            target_d = sw_s_q[1:0];
        end
        pending_d = (pending_q && !load_take) || bt_press || sel_chg || byp_chg;
    end

    // FSM next state and working/committed registers.
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        work_preset_d = work_preset_q;
        work_bypass_d = work_bypass_q;
        preset_d      = preset_q;
        bypass_d      = bypass_q;
        case (state_q)
            ST_IDLE: begin
                if (pending_q) begin
                    work_preset_d = target_q;
                    work_bypass_d = sw_s_q[2];
                    addr_d        = 4'd0;
                    state_d       = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (coef_ready_i) begin
                    if (addr_q == 4'd9) begin
                        addr_d  = 4'd0;
                        state_d = ST_WAIT_VS;
                    end else begin
                        addr_d = addr_q + 4'd1;
                    end
                end
            end
            ST_WAIT_VS: begin
                if (vs_rise || to_expire) begin
                    preset_d = work_preset_q;
                    bypass_d = work_bypass_q;
                    state_d  = ST_SWAP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        coef_valid_o = (state_q == ST_LOAD);
        coef_addr_o  = addr_q;
        coef_data_o  = '0;
        if (state_q == ST_LOAD) begin
            coef_data_o = rom_word(work_preset_q, addr_q);
        end
        coef_swap_o  = (state_q == ST_SWAP);
        busy_o       = (state_q != ST_IDLE);
        preset_o     = preset_q;
        bypass_o     = bypass_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            bt_meta_q     <= 1'b0;
            bt_sync_q     <= 1'b0;
            db_cnt_q      <= '0;
            db_level_q    <= 1'b0;
            sw_s_q        <= '0;
            sw_prev_q     <= '0;
            vs_s_q        <= 1'b0;
            vs_prev_q     <= 1'b0;
            pending_q     <= 1'b1;
            target_q      <= 2'd0;
            work_preset_q <= 2'd0;
            work_bypass_q <= 1'b0;
            addr_q        <= 4'd0;
            preset_q      <= 2'd0;
            bypass_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            bt_meta_q     <= bt_meta_d;
            bt_sync_q     <= bt_sync_d;
            db_cnt_q      <= db_cnt_d;
            db_level_q    <= db_level_d;
            sw_s_q        <= sw_s_d;
            sw_prev_q     <= sw_prev_d;
            vs_s_q        <= vs_s_d;
            vs_prev_q     <= vs_prev_d;
            pending_q     <= pending_d;
            target_q      <= target_d;
            work_preset_q <= work_preset_d;
            work_bypass_q <= work_bypass_d;
            addr_q        <= addr_d;
            preset_q      <= preset_d;
            bypass_q      <= bypass_d;
        end
    end

`ifdef FIR_COEF_VS_TIMEOUT_EN
    localparam int TO_W = $clog2(VS_TIMEOUT_CYC + 1);

    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            timeout_q, timeout_d;

    // Counter restarts on every WAIT_VS entry; expiry without a vsync edge is sticky.
    assign to_expire = (state_q == ST_WAIT_VS) && (to_cnt_q == TO_W'(VS_TIMEOUT_CYC - 1));

    always_comb begin
        to_cnt_d  = '0;
        if (state_q == ST_WAIT_VS) begin
            to_cnt_d = to_cnt_q + 1'b1;
        end
        timeout_d = timeout_q || (to_expire && !vs_rise);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            to_cnt_q  <= to_cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout_o = timeout_q;
`else
    assign to_expire = 1'b0;
    assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_fir_coef_ctrl.sv
// Directed bench for fir_coef_ctrl: preset loads, backpressure, debounce, deferred swaps, reset and timeout.
module tb_fir_coef_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] sw_i;
    logic [3:0] bt_i;
    logic       vs_i;
    logic       coef_valid_o;
    logic       coef_ready_i;
    logic [3:0] coef_addr_o;
    logic [7:0] coef_data_o;
    logic       coef_swap_o;
    logic       bypass_o;
    logic [1:0] preset_o;
    logic       busy_o;
    logic       timeout_o;

    int n_checks = 0;
    int n_fail   = 0;
    int cap_addr[$];
    int cap_data[$];
    int swap_cnt = 0;

    logic [7:0] exp_tab [4][10] = '{
        '{8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
        '{8'h01, 8'h02, 8'h01, 8'h02, 8'h04, 8'h02, 8'h01, 8'h02, 8'h01, 8'h04},
        '{8'h00, 8'hFF, 8'h00, 8'hFF, 8'h05, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'h00},
        '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h08, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00}
    };

    fir_coef_ctrl #(
        .COEF_W        (8),
        .SHIFT_W       (4),
        .DEBOUNCE_CYC  (16),
        .VS_TIMEOUT_CYC(100)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sw_i        (sw_i),
        .bt_i        (bt_i),
        .vs_i        (vs_i),
        .coef_valid_o(coef_valid_o),
        .coef_ready_i(coef_ready_i),
        .coef_addr_o (coef_addr_o),
        .coef_data_o (coef_data_o),
        .coef_swap_o (coef_swap_o),
        .bypass_o    (bypass_o),
        .preset_o    (preset_o),
        .busy_o      (busy_o),
        .timeout_o   (timeout_o)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst && coef_valid_o && coef_ready_i) begin
            cap_addr.push_back(int'(coef_addr_o));
            cap_data.push_back(int'(coef_data_o));
            $display("write addr=%0d data=0x%02h", coef_addr_o, coef_data_o);
        end
        if (!rst && coef_swap_o) begin
            swap_cnt++;
            $display("swap preset=%0d bypass=%0d", preset_o, bypass_o);
        end
    end

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    task automatic clear_cap();
        cap_addr.delete();
        cap_data.delete();
    endtask

    task automatic wait_writes(input int n, input string tag);
        for (int k = 0; k < 300; k++) begin
            @(posedge clk);
            if (cap_addr.size() >= n) break;
        end
        check_val({tag, "_nwrites"}, cap_addr.size(), n);
    endtask

    task automatic wait_valid(input string tag);
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (coef_valid_o) break;
        end
        check_val({tag, "_valid"}, coef_valid_o, 1);
    endtask

    task automatic check_load(input int p, input string tag);
        for (int i = 0; i < 10; i++) begin
            if (i < cap_addr.size()) begin
                check_val($sformatf("%s_addr%0d", tag, i), cap_addr[i], i);
                check_val($sformatf("%s_data%0d", tag, i), cap_data[i], exp_tab[p][i]);
            end
        end
    endtask

    task automatic vs_swap(input int exp_p, input int exp_b, input string tag);
        bit seen;
        seen = 1'b0;
        @(posedge clk);
        #1 vs_i = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (coef_swap_o) begin
                seen = 1'b1;
                break;
            end
        end
        vs_i = 1'b0;
        check_val({tag, "_swap_seen"}, seen, 1);
        check_val({tag, "_preset"}, preset_o, exp_p);
        check_val({tag, "_bypass"}, bypass_o, exp_b);
        @(negedge clk);
        check_val({tag, "_swap_1cyc"}, coef_swap_o, 0);
    endtask

    task automatic press_button(input int hold);
        @(posedge clk);
        #1 bt_i[0] = 1'b1;
        repeat (hold) @(posedge clk);
        #1 bt_i[0] = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        int k;
        rst = 1'b1; sw_i = 8'h00; bt_i = 4'h0; vs_i = 1'b0; coef_ready_i = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check_val("rst_valid", coef_valid_o, 0);
        check_val("rst_addr", coef_addr_o, 0);
        check_val("rst_data", coef_data_o, 0);
        check_val("rst_swap", coef_swap_o, 0);
        check_val("rst_bypass", bypass_o, 0);
        check_val("rst_preset", preset_o, 0);
        check_val("rst_busy", busy_o, 0);
        check_val("rst_timeout", timeout_o, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Preset 0 auto-loads after reset.
        wait_writes(10, "p0");
        check_load(0, "p0");
        @(negedge clk);
        check_val("p0_wait_busy", busy_o, 1);
        check_val("p0_wait_valid", coef_valid_o, 0);
        vs_swap(0, 0, "p0");

        // Switch select 2: committed preset changes only at the swap.
        clear_cap();
        sw_i = 8'h02;
        wait_writes(10, "p2");
        check_load(2, "p2");
        check_val("p2_preset_before_swap", preset_o, 0);
        vs_swap(2, 0, "p2");

        // Preset 1 with ready low for 3 cycles at address 4.
        clear_cap();
        coef_ready_i = 1'b0;
        sw_i = 8'h01;
        wait_valid("p1");
        @(posedge clk);
        #1 coef_ready_i = 1'b1;
        repeat (4) @(posedge clk);
        #1 coef_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_val("p1_hold_valid", coef_valid_o, 1);
            check_val("p1_hold_addr", coef_addr_o, 4);
            check_val("p1_hold_data", coef_data_o, 4);
        end
        @(posedge clk);
        #1 coef_ready_i = 1'b1;
        wait_writes(10, "p1");
        repeat (5) @(posedge clk);
        check_val("p1_exact_writes", cap_addr.size(), 10);
        check_load(1, "p1");
        vs_swap(1, 0, "p1");

        // Short glitch on the button is rejected.
        clear_cap();
        press_button(10);
        repeat (40) @(posedge clk);
        check_val("glitch_busy", busy_o, 0);
        check_val("glitch_writes", cap_addr.size(), 0);

        // Held presses step the target 1 -> 2 -> 3 -> 0.
        press_button(40);
        wait_writes(10, "bt1");
        check_load(2, "bt1");
        vs_swap(2, 0, "bt1");
        repeat (40) @(posedge clk);
        clear_cap();
        press_button(40);
        wait_writes(10, "bt2");
        check_load(3, "bt2");
        vs_swap(3, 0, "bt2");
        repeat (40) @(posedge clk);
        clear_cap();
        press_button(40);
        wait_writes(10, "bt3");
        check_load(0, "bt3");
        vs_swap(0, 0, "bt3");
        repeat (40) @(posedge clk);

        // Request during WAIT_VS: old preset swaps first, new one reloads right after.
        clear_cap();
        s0 = swap_cnt;
        sw_i = 8'h02;
        wait_writes(10, "ws");
        @(posedge clk);
        #1 sw_i = 8'h83;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check_val("ws_still_waiting", busy_o, 1);
        check_val("ws_no_valid", coef_valid_o, 0);
        vs_swap(2, 0, "ws_old");
        clear_cap();
        wait_writes(10, "ws_new");
        check_load(3, "ws_new");
        vs_swap(3, 1, "ws_new");
        repeat (3) @(posedge clk);
        check_val("ws_two_swaps", swap_cnt - s0, 2);

        // Reset mid-load returns everything to reset values.
        clear_cap();
        sw_i = 8'h81;
        wait_valid("mid");
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("mid_rst_valid", coef_valid_o, 0);
        check_val("mid_rst_busy", busy_o, 0);
        check_val("mid_rst_preset", preset_o, 0);
        check_val("mid_rst_bypass", bypass_o, 0);
        clear_cap();
        @(posedge clk);
        #1 rst = 1'b0;
        wait_writes(10, "mid_p0");
        check_load(0, "mid_p0");
        vs_swap(0, 0, "mid_p0");
        clear_cap();
        wait_writes(10, "mid_p1");
        check_load(1, "mid_p1");
        vs_swap(1, 1, "mid_p1");

`ifdef FIR_COEF_VS_TIMEOUT_EN
        // No vsync: swap is forced after the timeout and the flag sticks until reset.
        clear_cap();
        sw_i = 8'h02;
        wait_writes(10, "to");
        k = 0;
        for (int i = 1; i <= 300; i++) begin
            @(negedge clk);
            if (coef_swap_o) begin
                k = i;
                break;
            end
        end
        check_val("to_swap_cycle_in_window", (k >= 100 && k <= 101), 1);
        check_val("to_preset", preset_o, 2);
        repeat (20) @(posedge clk);
        @(negedge clk);
        check_val("to_flag_sticky", timeout_o, 1);
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("to_flag_cleared", timeout_o, 0);
        #1 rst = 1'b0;
`else
        k = 0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        check_val("no_timeout_flag", timeout_o, k);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
